// File: rtl/gate_truth_checker_if.sv
// Stimulus/response bundle between gate_truth_checker (master) and the gate
// environment (slave).
interface gate_truth_checker_if;
    // start is a level request, sampled only while the checker is idle; done is a
    // one-cycle pulse, and pass/fail_mask stay valid from done until the next
    // accepted start.
    logic       start;
    logic       x_out;
    logic       y_out;
    logic       z_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    logic [1:0] state_dbg;

    modport master (
        input  start, z_in,
        output x_out, y_out, busy, done, pass, fail_mask, state_dbg
    );

    modport slave (
        output start, z_in,
        input  x_out, y_out, busy, done, pass, fail_mask, state_dbg
    );
endinterface

// File: rtl/gate_truth_checker.sv
// Drives the four {x,y} vectors into a 2-input gate and checks z against TRUTH.
// Optional build macro GATE_TRUTH_CHECKER_HALT_EN: stop the run at the first mismatch.
module gate_truth_checker #(
    parameter logic [3:0]  TRUTH  = 4'b0111,
    parameter int unsigned SETTLE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    gate_truth_checker_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef GATE_TRUTH_CHECKER_HALT_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       x_q, x_d;
    logic       y_q, y_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] mask_q, mask_d;
    logic       mism;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mask_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        mask_d  = mask_q;
        mism    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = HOLD;
                    idx_d      = 2'd0;
                    {x_d, y_d} = 2'b00;
                    cnt_d      = SETTLE_C;
                    mask_d     = 4'd0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mism = (bus.z_in != TRUTH[idx_q]);
                    if (mism) begin
                        mask_d[idx_q] = 1'b1;
                    end
                    // pass is judged on the mask including this final sample.
                    if ((idx_q == 2'd3) || (HALT && mism)) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        {x_d, y_d} = 2'b00;
                        pass_d     = (mask_d == 4'd0);
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        {x_d, y_d} = idx_d;
                        cnt_d      = SETTLE_C;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.x_out     = x_q;
    assign bus.y_out     = y_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = mask_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: four instances cover NAND, AND,
// stuck-at-1 with zero settle, and stuck-at-0 gates.
module tb_gate_truth_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c, rst_d;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [1:0] exp_q[$];

    gate_truth_checker_if bus_a ();
    gate_truth_checker_if bus_b ();
    gate_truth_checker_if bus_c ();
    gate_truth_checker_if bus_d ();

    assign bus_a.z_in = ~(bus_a.x_out & bus_a.y_out);
    assign bus_b.z_in = bus_b.x_out & bus_b.y_out;
    assign bus_c.z_in = 1'b1;
    assign bus_d.z_in = 1'b0;

    gate_truth_checker u_a (.clk(clk), .rst(rst_a), .bus(bus_a.master));
    gate_truth_checker #(.TRUTH(4'b0111)) u_b (.clk(clk), .rst(rst_b), .bus(bus_b.master));
    gate_truth_checker #(.SETTLE(0)) u_c (.clk(clk), .rst(rst_c), .bus(bus_c.master));
    gate_truth_checker u_d (.clk(clk), .rst(rst_d), .bus(bus_d.master));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0: bus_a.start = v;
            1: bus_b.start = v;
            2: bus_c.start = v;
            default: bus_d.start = v;
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0: return bus_a.done;
            1: return bus_b.done;
            2: return bus_c.done;
            default: return bus_d.done;
        endcase
    endfunction

    function automatic logic [1:0] get_xy(input int sel);
        case (sel)
            0: return {bus_a.x_out, bus_a.y_out};
            1: return {bus_b.x_out, bus_b.y_out};
            2: return {bus_c.x_out, bus_c.y_out};
            default: return {bus_d.x_out, bus_d.y_out};
        endcase
    endfunction

    function automatic logic [4:0] get_res(input int sel);
        case (sel)
            0: return {bus_a.pass, bus_a.fail_mask};
            1: return {bus_b.pass, bus_b.fail_mask};
            2: return {bus_c.pass, bus_c.fail_mask};
            default: return {bus_d.pass, bus_d.fail_mask};
        endcase
    endfunction

    // Pulse start so it is accepted at E0, then count edges until done shows.
    task automatic run(input int sel, output int cycles, output logic xy_moved);
        cycles   = 0;
        xy_moved = 1'b0;
        set_start(sel, 1'b1);
        step();
        set_start(sel, 1'b0);
        while (!get_done(sel) && cycles < 40) begin
            step();
            cycles++;
            if (get_xy(sel) != 2'b00) xy_moved = 1'b1;
        end
        if (!get_done(sel)) check("run_timeout", 32'(cycles), 32'd0);
    endtask

    int   cyc;
    logic moved;
    int   done_cnt;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
        bus_a.start = 1'b0; bus_b.start = 1'b0; bus_c.start = 1'b0; bus_d.start = 1'b0;
        step();
        bus_a.start = 1'b1;
        step();
        check("rst_xy", 32'(get_xy(0)), 32'd0);
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        check("rst_done", 32'(bus_a.done), 32'd0);
        check("rst_pass_mask", 32'(get_res(0)), 32'd0);
        check("rst_state", 32'(bus_a.state_dbg), 32'd0);
        bus_a.start = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
        step();

        // NAND with default params: each vector held two cycles, done after E0+8.
        for (int k = 0; k < 8; k++) exp_q.push_back(2'(k / 2));
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
        check("nand_busy_e0", 32'(bus_a.busy), 32'd1);
        check("nand_xy_e0", 32'(get_xy(0)), 32'(exp_q.pop_front()));
        for (int k = 1; k <= 8; k++) begin
            step();
            check("nand_busy", 32'(bus_a.busy), (k < 8) ? 32'd1 : 32'd0);
            check("nand_done", 32'(bus_a.done), (k == 8) ? 32'd1 : 32'd0);
            if (k < 8) check("nand_xy", 32'(get_xy(0)), 32'(exp_q.pop_front()));
            else check("nand_xy_done", 32'(get_xy(0)), 32'd0);
        end
        check("nand_result", 32'(get_res(0)), 32'h10);
        step();
        check("nand_done_pulse", 32'(bus_a.done), 32'd0);
        check("nand_result_hold", 32'(get_res(0)), 32'h10);
        step();

        // AND gate checked against NAND truth: every vector mismatches.
        run(1, cyc, moved);
        check("and_cycles", 32'(cyc), 32'd8);
        check("and_result", 32'(get_res(1)), 32'h0F);

        // Stuck-at-1 output, zero settle: only 11 mismatches.
        run(2, cyc, moved);
        check("s1_cycles", 32'(cyc), 32'd4);
        check("s1_result", 32'(get_res(2)), 32'h08);

        // Stuck-at-0 output against NAND truth.
        run(3, cyc, moved);
`ifdef GATE_TRUTH_CHECKER_HALT_EN
        check("s0_cycles", 32'(cyc), 32'd2);
        check("s0_result", 32'(get_res(3)), 32'h01);
        check("s0_xy_moved", 32'(moved), 32'd0);
`else
        check("s0_cycles", 32'(cyc), 32'd8);
        check("s0_result", 32'(get_res(3)), 32'h07);
        check("s0_xy_moved", 32'(moved), 32'd1);
`endif
        step();

        // Reset sampled at E0+3 aborts the run without a done pulse.
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
        step();
        step();
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        check("abort_xy", 32'(get_xy(0)), 32'd0);
        check("abort_busy_done", 32'({bus_a.busy, bus_a.done}), 32'd0);
        check("abort_result", 32'(get_res(0)), 32'd0);
        check("abort_state", 32'(bus_a.state_dbg), 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus_a.done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run(0, cyc, moved);
        check("rerun_cycles", 32'(cyc), 32'd8);
        check("rerun_result", 32'(get_res(0)), 32'h10);
        step();
        step();

        // start re-pulsed mid-run is ignored; held high it restarts at E0+10.
        bus_a.start = 1'b1;
        step();
        done_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            bus_a.start = (k == 2 || k == 5 || k >= 7);
            step();
            if (bus_a.done) begin
                done_cnt++;
                check("repulse_done_edge", 32'(k), 32'd8);
            end
            if (k == 9) check("repulse_idle_gap", 32'(bus_a.busy), 32'd0);
        end
        check("repulse_done_count", 32'(done_cnt), 32'd1);
        check("second_run_busy", 32'(bus_a.busy), 32'd1);
        check("second_run_state", 32'(bus_a.state_dbg), 32'd1);
        bus_a.start = 1'b0;
        cyc = 0;
        while (!bus_a.done && cyc < 40) begin
            step();
            cyc++;
        end
        check("second_run_cycles", 32'(cyc), 32'd8);
        check("second_run_result", 32'(get_res(0)), 32'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
